// File: rtl/dff_share_arbiter.sv
// dff_share_arbiter: round-robin write arbiter in front of one shared
// DATA_W-bit storage register. At most one requester is granted per cycle and
// its data is loaded on the following posedge. The block also tracks which
// requester wrote last and counts accepted writes.
//
// Ports:
//   clk_i      single clock, all state updates on posedge
//   rst_i      synchronous active-low reset
//   req_i      per-requester write request, bit k = requester k
//   data_i     per-requester data, slice k = data_i[k*DATA_W +: DATA_W]
//   clr_i      synchronous clear of stored data (suppresses grants)
//   gnt_o      one-hot grant, combinational from req_i, ptr, clr_i, rst_i
//   q_o        stored register value
//   q_valid_o  register holds data written since reset/clear
//   owner_o    index of the requester that performed the last write
//   wr_cnt_o   number of accepted writes, wraps
module dff_share_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned IDX_W  = $clog2(N_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   data_i,
  input  logic                      clr_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [DATA_W-1:0]         q_o,
  output logic                      q_valid_o,
  output logic [IDX_W-1:0]          owner_o,
  output logic [CNT_W-1:0]          wr_cnt_o
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [IDX_W-1:0]  ptr;
  logic [N_REQ-1:0]  gnt;
  logic              found;
  logic [SUM_W-1:0]  idx_sum;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  win_idx;
  logic [DATA_W-1:0] win_data;
  logic              xfer;

  // Rotating search ptr, ptr+1, ... modulo N_REQ; first asserted request wins.
  // The modulo is an explicit subtract so non-power-of-two N_REQ works.
  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    idx_sum = '0;
    idx     = '0;
    if (rst_i && !clr_i) begin
      for (int i = 0; i < N_REQ; i++) begin
        idx_sum = {1'b0, ptr} + SUM_W'(i);
        if (idx_sum >= SUM_W'(N_REQ)) begin
          idx_sum = idx_sum - SUM_W'(N_REQ);
        end
        idx = idx_sum[IDX_W-1:0];
        for (int k = 0; k < N_REQ; k++) begin
          if (!found && (idx == IDX_W'(k)) && req_i[k]) begin
            gnt[k] = 1'b1;
            found  = 1'b1;
          end
        end
      end
    end
  end

  // Decode the one-hot grant into the winning index and its data slice.
  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        win_idx  = IDX_W'(k);
        win_data = data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign xfer  = found;
  assign gnt_o = gnt;

  // Shared storage register plus owner / write-count / pointer bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      q_o       <= '0;
      q_valid_o <= 1'b0;
      owner_o   <= '0;
      wr_cnt_o  <= '0;
      ptr       <= '0;
    end else if (clr_i) begin
      q_o       <= '0;
      q_valid_o <= 1'b0;
    end else if (xfer) begin
      q_o       <= win_data;
      q_valid_o <= 1'b1;
      owner_o   <= win_idx;
      wr_cnt_o  <= wr_cnt_o + CNT_W'(1);
      ptr       <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Testbench for dff_share_arbiter: directed scenarios plus random traffic,
// all checked against a behavioural model of the register and rotating pointer.
module tb_dff_share_arbiter;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 2;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ*DATA_W-1:0] data_i;
  logic                    clr_i;
  logic [N_REQ-1:0]        gnt_o;
  logic [DATA_W-1:0]       q_o;
  logic                    q_valid_o;
  logic [IDX_W-1:0]        owner_o;
  logic [CNT_W-1:0]        wr_cnt_o;

  always #5 clk_i = ~clk_i;

  dff_share_arbiter #(
    .N_REQ (N_REQ),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .data_i   (data_i),
    .clr_i    (clr_i),
    .gnt_o    (gnt_o),
    .q_o      (q_o),
    .q_valid_o(q_valid_o),
    .owner_o  (owner_o),
    .wr_cnt_o (wr_cnt_o)
  );

  int total = 0;
  int bad   = 0;

  // Model state.
  int unsigned m_q;
  int unsigned m_valid;
  int unsigned m_owner;
  int unsigned m_cnt;
  int unsigned m_ptr;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Index granted under round-robin order starting at m_ptr, or -1.
  function automatic int model_pick(input logic [N_REQ-1:0] req);
    for (int i = 0; i < N_REQ; i++) begin
      int k;
      k = (int'(m_ptr) + i) % N_REQ;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  // One clock: apply inputs, check grant mid-cycle, advance model, check state.
  task automatic step(input logic rst, input logic [N_REQ-1:0] req,
                      input logic [N_REQ*DATA_W-1:0] data, input logic clr,
                      output int g);
    logic [N_REQ-1:0] exp_gnt;
    @(negedge clk_i);
    rst_i  = rst;
    req_i  = req;
    data_i = data;
    clr_i  = clr;
    #1;
    g = (rst && !clr) ? model_pick(req) : -1;
    exp_gnt = (g >= 0) ? (N_REQ'(1) << g) : '0;
    check("gnt", gnt_o, exp_gnt);
    @(posedge clk_i);
    if (!rst) begin
      m_q = 0; m_valid = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    end else if (clr) begin
      m_q = 0; m_valid = 0;
    end else if (g >= 0) begin
      m_q     = int'(data[g*DATA_W +: DATA_W]);
      m_valid = 1;
      m_owner = g;
      m_cnt   = (m_cnt + 1) % (1 << CNT_W);
      m_ptr   = (g + 1) % N_REQ;
    end
    #1;
    check("q", q_o, m_q);
    check("q_valid", q_valid_o, m_valid);
    check("owner", owner_o, m_owner);
    check("wr_cnt", wr_cnt_o, m_cnt);
  endtask

  initial begin
    int g;
    logic [N_REQ*DATA_W-1:0] d;
    rst_i = 1'b0; req_i = '0; data_i = '0; clr_i = 1'b0;
    m_q = 0; m_valid = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;

    // Reset with all requests active: no grant, reset values load.
    repeat (2) begin
      step(1'b0, 4'b1111, '1, 1'b0, g);
      check("rst_gnt_lit", gnt_o, 0);
    end
    check("rst_q_lit", q_o, 0);
    check("rst_valid_lit", q_valid_o, 0);
    check("rst_cnt_lit", wr_cnt_o, 0);
    check("rst_owner_lit", owner_o, 0);

    // Single write from requester 2.
    step(1'b1, 4'b0100, 32'h00A5_0000, 1'b0, g);
    check("t2_g_lit", g, 2);
    check("t2_q_lit", q_o, 8'hA5);
    check("t2_valid_lit", q_valid_o, 1);
    check("t2_owner_lit", owner_o, 2);
    check("t2_cnt_lit", wr_cnt_o, 1);

    // ptr=3 with requests 0 and 3: 3 first, then wrap to 0.
    step(1'b1, 4'b1001, 32'h3300_0030, 1'b0, g);
    check("t4_g0_lit", g, 3);
    check("t4_owner0_lit", owner_o, 3);
    step(1'b1, 4'b1001, 32'h3300_0030, 1'b0, g);
    check("t4_g1_lit", g, 0);
    check("t4_owner1_lit", owner_o, 0);

    // Move ptr back to 0 via a requester-3 write.
    step(1'b1, 4'b1000, 32'h4400_0000, 1'b0, g);
    check("ptr0_g_lit", g, 3);

    // All requesters active for 8 cycles: strict rotation.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'b1111, 32'h1312_1110, 1'b0, g);
      check("t3_g_lit", g, i % 4);
      check("t3_q_lit", q_o, 8'h10 + (i % 4));
    end
    check("t3_cnt_lit", wr_cnt_o, 12);

    // Clear suppresses grant; request stays pending and wins next cycle.
    step(1'b1, 4'b0010, 32'h0000_5500, 1'b1, g);
    check("t5_q_lit", q_o, 0);
    check("t5_valid_lit", q_valid_o, 0);
    check("t5_owner_lit", owner_o, 3);
    check("t5_cnt_lit", wr_cnt_o, 12);
    step(1'b1, 4'b0010, 32'h0000_5500, 1'b0, g);
    check("t5_g_lit", g, 1);
    check("t5_q2_lit", q_o, 8'h55);

    // Reset pulse mid-stream discards the pending write.
    step(1'b1, 4'b0001, 32'h0000_0077, 1'b0, g);
    step(1'b0, 4'b0001, 32'h0000_0088, 1'b0, g);
    check("t6_rst_q_lit", q_o, 0);
    check("t6_rst_cnt_lit", wr_cnt_o, 0);
    check("t6_rst_valid_lit", q_valid_o, 0);

    // Drive wr_cnt to its maximum, then one more write wraps it.
    for (int i = 0; i < 65535; i++) begin
      step(1'b1, 4'b0001, DATA_W'(i) & 32'h0000_00FF, 1'b0, g);
    end
    check("wrap_max_lit", wr_cnt_o, 16'hFFFF);
    step(1'b1, 4'b0001, 32'h0000_0042, 1'b0, g);
    check("wrap_zero_lit", wr_cnt_o, 16'h0000);
    check("wrap_q_lit", q_o, 8'h42);

    // Random traffic with occasional clear and reset.
    for (int i = 0; i < 2000; i++) begin
      d = {$urandom, $urandom};
      step(($urandom_range(0, 49) != 0),
           N_REQ'($urandom),
           d,
           ($urandom_range(0, 19) == 0), g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
